// File: rtl/diff_scaler.sv
// diff_scaler: two-stage op/scale/offset/clamp datapath, 2-cycle latency, 1 sample/cycle, no backpressure.
// Optional DIFF_SCALER_ROUND_EN selects round-half-up instead of truncation when halving.
module diff_scaler #(
  parameter int DW = 14,
  parameter int AW = 16
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [DW-1:0] plus,
  input  logic [DW-1:0] minus,
  output logic [DW-1:0] out,
  input  logic [AW-1:0] addr,
  input  logic          wen,
  input  logic          ren,
  output logic          ack,
  output logic [31:0]   rdata,
  input  logic [31:0]   wdata
);

  localparam logic [AW-1:0] A_MODE   = AW'(8'h00);
  localparam logic [AW-1:0] A_OFFSET = AW'(8'h04);
  localparam logic [AW-1:0] A_SATCNT = AW'(8'h08);
  localparam logic [AW-1:0] A_STATUS = AW'(8'h0C);
  localparam logic [DW+1:0] ONE_X    = (DW+2)'(1);
  localparam logic [DW-1:0] POS_MAX  = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0] NEG_MIN  = {1'b1, {(DW-1){1'b0}}};

  logic [1:0]    mode_op;
  logic          mode_scale;
  logic [DW-1:0] offset_q;
  logic [31:0]   satcnt;
  logic          sat_flag;
  logic [DW:0]   r1;

  logic [DW:0]   a_x, b_x, op_res;
  logic [DW+1:0] r1_x, half_src, s, off_x, t;
  logic          sat;
  logic [DW-1:0] out_d;
  logic [31:0]   rd_mux;
  logic          wr_mode, wr_offset, wr_satcnt, wr_status;
  logic          unused_wdata;

  assign unused_wdata = &{1'b0, wdata[31:DW]};

  // Stage 1: one extra bit keeps every op result exact.
  assign a_x = {plus[DW-1], plus};
  assign b_x = {minus[DW-1], minus};

  always_comb begin
    op_res = a_x;
    case (mode_op)
      2'd0:    op_res = a_x - b_x;
      2'd1:    op_res = a_x + b_x;
      2'd2:    op_res = b_x - a_x;
      default: op_res = a_x;
    endcase
  end

  // Stage 2: two guard bits cover the full-scale result plus any offset.
  assign r1_x = {r1[DW], r1};
`ifdef DIFF_SCALER_ROUND_EN
  assign half_src = r1_x + ONE_X;
`else
  assign half_src = r1_x;
`endif
  assign s     = mode_scale ? r1_x : {half_src[DW+1], half_src[DW+1:1]};
  assign off_x = {{2{offset_q[DW-1]}}, offset_q};
  assign t     = s + off_x;

  // Overflow whenever the bits above the result's sign bit disagree with it.
  assign sat   = (t[DW+1:DW-1] != '0) && (t[DW+1:DW-1] != '1);
  assign out_d = sat ? (t[DW+1] ? NEG_MIN : POS_MAX) : t[DW-1:0];

  assign wr_mode   = wen && (addr == A_MODE);
  assign wr_offset = wen && (addr == A_OFFSET);
  assign wr_satcnt = wen && (addr == A_SATCNT);
  assign wr_status = wen && (addr == A_STATUS);

  always_comb begin
    rd_mux = '0;
    case (addr)
      A_MODE:   rd_mux = {29'b0, mode_scale, mode_op};
      A_OFFSET: rd_mux = {{(32-DW){offset_q[DW-1]}}, offset_q};
      A_SATCNT: rd_mux = satcnt;
      A_STATUS: rd_mux = {31'b0, sat_flag};
      default:  rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r1         <= '0;
      out        <= '0;
      mode_op    <= '0;
      mode_scale <= 1'b0;
      offset_q   <= '0;
      satcnt     <= '0;
      sat_flag   <= 1'b0;
      ack        <= 1'b0;
      rdata      <= '0;
    end else begin
      r1  <= op_res;
      out <= out_d;
      ack <= wen || ren;
      // rd_mux reflects pre-write state, so a simultaneous write is not visible.
      if (ren) rdata <= rd_mux;

      if (wr_mode) begin
        mode_op    <= wdata[1:0];
        mode_scale <= wdata[2];
      end
      if (wr_offset) offset_q <= wdata[DW-1:0];

      if (wr_satcnt)                  satcnt <= sat ? 32'd1 : 32'd0;
      else if (sat && (satcnt != '1)) satcnt <= satcnt + 32'd1;

      if (sat)                        sat_flag <= 1'b1;
      else if (wr_status && wdata[0]) sat_flag <= 1'b0;
    end
  end

endmodule

// File: tb/tb_diff_scaler.sv
// Directed-vector bench for diff_scaler: datapath modes, clamping, rounding, register bus corners, mid-stream reset.
module tb_diff_scaler;
  localparam int DW = 14;
  localparam int AW = 16;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic [DW-1:0] plus, minus, out;
  logic [AW-1:0] addr;
  logic          wen, ren, ack;
  logic [31:0]   rdata, wdata;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  diff_scaler #(.DW(DW), .AW(AW)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .plus(plus), .minus(minus), .out(out),
    .addr(addr), .wen(wen), .ren(ren), .ack(ack), .rdata(rdata), .wdata(wdata)
  );

  task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic signed [31:0] sx(input logic [DW-1:0] v);
    return {{(32-DW){v[DW-1]}}, v};
  endfunction

  // Called at a falling edge; returns at the next falling edge with ack/rdata sampled.
  task automatic bus(input logic w, input logic r, input logic [AW-1:0] a, input logic [31:0] d,
                     output logic [31:0] rd, output logic ak);
    wen = w; ren = r; addr = a; wdata = d;
    @(negedge clk_i);
    rd = rdata; ak = ack;
    wen = 1'b0; ren = 1'b0;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [31:0] d);
    logic [31:0] rd;
    logic ak;
    bus(1'b1, 1'b0, a, d, rd, ak);
  endtask

  task automatic rd_chk(input string tag, input logic [AW-1:0] a, input logic [31:0] exp);
    logic [31:0] rd;
    logic ak;
    bus(1'b0, 1'b1, a, 32'd0, rd, ak);
    check(tag, rd, exp);
  endtask

  // One-cycle input sample, then zeros; returns out when that sample reaches it.
  task automatic pulse(input int p, input int m, output logic signed [31:0] o);
    plus = p[DW-1:0]; minus = m[DW-1:0];
    @(negedge clk_i);
    plus = '0; minus = '0;
    @(negedge clk_i);
    o = sx(out);
  endtask

  initial begin
    logic signed [31:0] o;
    logic [31:0] rd;
    logic ak;

    rst_i = 1'b1; plus = '0; minus = '0; addr = '0; wen = 1'b0; ren = 1'b0; wdata = '0;
    repeat (2) @(negedge clk_i);
    check("rst_out", sx(out), 0);
    check("rst_ack", 32'(ack), 0);
    check("rst_rdata", rdata, 0);
    rst_i = 1'b0;

    // MODE 0: (1000 - -1000) / 2, two cycles of latency
    plus = 14'd1000; minus = -14'sd1000;
    @(negedge clk_i);
    check("lat_1cyc", sx(out), 0);
    @(negedge clk_i);
    check("mode0_out", sx(out), 1000);
    plus = '0; minus = '0;
    rd_chk("satcnt_init", 16'h08, 0);
    rd_chk("mode_init", 16'h00, 0);

    // Full-scale positive and negative clamping
    wr(16'h00, 4);
    pulse(8191, -8192, o);
    check("sat_pos", o, 8191);
    rd_chk("satcnt_1", 16'h08, 1);
    rd_chk("status_1", 16'h0C, 1);
    wr(16'h0C, 1);
    rd_chk("status_clr", 16'h0C, 0);
    pulse(-8192, 8191, o);
    check("sat_neg", o, -8192);
    rd_chk("satcnt_2", 16'h08, 2);

    // Ops with offset, full scale
    wr(16'h00, 5); wr(16'h04, 100);
    pulse(50, 20, o);  check("op_add_off", o, 170);
    wr(16'h00, 7);
    pulse(50, 20, o);  check("op_plus_off", o, 150);
    wr(16'h00, 6);
    pulse(50, 20, o);  check("op_rsub_off", o, 70);

    // Clamp boundary with offset 1
    wr(16'h04, 1); wr(16'h00, 7);
    pulse(8190, 0, o); check("edge_nosat", o, 8191);
    pulse(8191, 0, o); check("edge_sat", o, 8191);
    rd_chk("satcnt_3", 16'h08, 3);

    // Register readback: sign extension and unused MODE bits
    wr(16'h04, 32'h0000_3FFB);
    rd_chk("offset_sx", 16'h04, 32'hFFFF_FFFB);
    wr(16'h04, 0);
    wr(16'h00, 32'hFFFF_FFFE);
    rd_chk("mode_mask", 16'h00, 6);

    // Halving of odd values
    wr(16'h00, 0);
    pulse(3, 0, o);
`ifdef DIFF_SCALER_ROUND_EN
    check("half_p3", o, 2);
`else
    check("half_p3", o, 1);
`endif
    pulse(-3, 0, o);
`ifdef DIFF_SCALER_ROUND_EN
    check("half_m3", o, -1);
`else
    check("half_m3", o, -2);
`endif

    // Unmapped read replaces a non-zero rdata with 0
    rd_chk("prime_rd", 16'h08, 3);
    bus(1'b0, 1'b1, 16'h10, 32'd0, rd, ak);
    check("unmap_ack", 32'(ak), 1);
    check("unmap_rdata", rd, 0);
    @(negedge clk_i);
    check("ack_drop", 32'(ack), 0);
    check("rdata_hold", rdata, 0);

    // SATCNT clear colliding with an event
    wr(16'h00, 4);
    plus = 14'd8191; minus = -14'sd8192;
    @(negedge clk_i);
    plus = '0; minus = '0;
    bus(1'b1, 1'b0, 16'h08, 32'd0, rd, ak);
    rd_chk("satclr_evt", 16'h08, 1);

    // STATUS w1c colliding with an event
    wr(16'h0C, 1);
    plus = 14'd8191; minus = -14'sd8192;
    @(negedge clk_i);
    plus = '0; minus = '0;
    bus(1'b1, 1'b0, 16'h0C, 32'd1, rd, ak);
    rd_chk("w1c_evt", 16'h0C, 1);

    // Five consecutive saturating samples
    wr(16'h08, 0);
    plus = 14'd8191; minus = -14'sd8192;
    repeat (5) @(negedge clk_i);
    plus = '0; minus = '0;
    @(negedge clk_i);
    rd_chk("satcnt_5", 16'h08, 5);

    // Simultaneous read and write returns the old value
    bus(1'b1, 1'b1, 16'h04, 32'd7, rd, ak);
    check("rw_old", rd, 0);
    check("rw_ack", 32'(ak), 1);
    rd_chk("rw_new", 16'h04, 7);
    wr(16'h04, 0);

    // Reset in the middle of a stream
    plus = 14'd1000; minus = -14'sd1000;
    repeat (2) @(negedge clk_i);
    check("pre_rst", sx(out), 2000);
    rst_i = 1'b1;
    @(negedge clk_i);
    check("mid_rst_out", sx(out), 0);
    rst_i = 1'b0;
    bus(1'b0, 1'b1, 16'h08, 32'd0, rd, ak);
    check("mid_rst_sat", rd, 0);
    check("post_rst_1", sx(out), 0);
    @(negedge clk_i);
    check("post_rst_2", sx(out), 1000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
